// File: rtl/temp_sense_sequencer.sv
// temp_sense_sequencer: schedules SPI reads of an LM07/LM70-family sensor,
// generates CS/SCK, shifts in the 16-bit word MSB first and publishes the
// raw word, the 8-MSB reading and an over-temperature flag.
//
// Request/result protocol: start (and the internal period timer) are
// one-cycle requests with no back-pressure; they are remembered in a single
// pending flag, so any number of requests before the next IDLE merge into one
// read. data_valid is a one-cycle strobe with no ready; temp_raw/temp_data/
// alarm are held until the next strobe, so a consumer may sample them at any
// later time.
module temp_sense_sequencer #(
  parameter int SCK_DIV       = 2,
  parameter int CS_SETUP      = 2,
  parameter int SAMPLE_PERIOD = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        start,
  input  logic [7:0]  thresh,
  input  logic        sio,
  output logic        cs,
  output logic        sck,
  output logic        busy,
  output logic [15:0] temp_raw,
  output logic [7:0]  temp_data,
  output logic        data_valid,
  output logic        alarm
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_t;

  localparam int PW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam logic [PW-1:0] PERIOD_LAST = PW'(SAMPLE_PERIOD - 1);
  localparam logic [PW-1:0] PERIOD_ONE  = PW'(1);
  localparam logic [15:0]   SETUP_LAST  = 16'(CS_SETUP - 1);
  localparam logic [15:0]   DIV_LAST    = 16'(SCK_DIV - 1);

  // FSM state is kept as a named signal so checkers can bind to it.
  state_t        state;
  logic [PW-1:0] period_cnt;
  logic          pending;
  logic          wrap;
  logic [15:0]   cnt;
  logic [3:0]    bit_idx;
  logic [15:0]   shift;

  // Timer wrap is a read request; only meaningful while the timer runs.
  assign wrap = enable && (period_cnt == PERIOD_LAST);

  // Free-running sample period counter, held at zero while disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      period_cnt <= '0;
    end else if (!enable || wrap) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + PERIOD_ONE;
    end
  end

  // Request merging plus the frame sequencer with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pending    <= 1'b0;
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      cs         <= 1'b1;
      sck        <= 1'b0;
      busy       <= 1'b0;
      temp_raw   <= '0;
      temp_data  <= '0;
      data_valid <= 1'b0;
      alarm      <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      // A request in the same cycle IDLE consumes the flag is kept, so it
      // is served by a following frame rather than lost.
      pending    <= pending || start || wrap;
      case (state)
        IDLE: begin
          if (pending) begin
            pending <= start || wrap;
            cs      <= 1'b0;
            busy    <= 1'b1;
            cnt     <= '0;
            state   <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == SETUP_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= SHIFT;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        SHIFT: begin
          // sck itself tells which half of the bit period we are in.
          if (cnt == DIV_LAST) begin
            cnt <= '0;
            if (!sck) begin
              sck   <= 1'b1;
              shift <= {shift[14:0], sio};
            end else begin
              sck <= 1'b0;
              if (bit_idx == 4'd15) begin
                state <= HOLD;
              end else begin
                bit_idx <= bit_idx + 4'd1;
              end
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        HOLD: begin
          if (cnt == SETUP_LAST) begin
            cnt        <= '0;
            cs         <= 1'b1;
            temp_raw   <= shift;
            temp_data  <= shift[15:8];
            alarm      <= (shift[15:8] >= thresh);
            data_valid <= 1'b1;
            state      <= GAP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        GAP: begin
          if (cnt == SETUP_LAST) begin
            cnt   <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_temp_sense_sequencer.sv
// Testbench for temp_sense_sequencer: LM07-style sensor model, a frame-level
// reference model, a per-cycle compare process and directed + random stimulus.
module tb_temp_sense_sequencer;

  localparam int SD  = 2;
  localparam int CSS = 2;
  localparam int P   = 100;
  localparam int L   = 2 * CSS + 32 * SD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  thresh = 8'h00;
  logic        sio;
  logic        cs;
  logic        sck;
  logic        busy;
  logic [15:0] temp_raw;
  logic [7:0]  temp_data;
  logic        data_valid;
  logic        alarm;

  int checks = 0;
  int errors = 0;

  // Clock
  always #5 clk = ~clk;

  temp_sense_sequencer #(
    .SCK_DIV(SD),
    .CS_SETUP(CSS),
    .SAMPLE_PERIOD(P)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .start(start),
    .thresh(thresh),
    .sio(sio),
    .cs(cs),
    .sck(sck),
    .busy(busy),
    .temp_raw(temp_raw),
    .temp_data(temp_data),
    .data_valid(data_valid),
    .alarm(alarm)
  );

  // Sensor: latches its word when CS falls, presents the MSB, shifts on SCK fall.
  logic [15:0] sensor_word = 16'h0000;
  logic [15:0] sensor_sh = 16'h0000;
  always @(negedge cs) sensor_sh = sensor_word;
  always @(negedge sck) if (!cs) sensor_sh = {sensor_sh[14:0], 1'b0};
  assign sio = cs ? 1'b0 : sensor_sh[15];

  // Reference model: tracks frames by their age m_t in cycles since CS fell.
  int          m_cnt = 0;
  bit          m_pending = 0;
  bit          m_in_frame = 0;
  int          m_t = 0;
  logic [15:0] m_word = 16'h0000;
  logic [15:0] m_raw = 16'h0000;
  logic        m_alarm = 1'b0;
  logic        m_dv = 1'b0;

  always @(posedge clk) begin
    bit req;
    bit consume;
    if (rst) begin
      m_cnt = 0; m_pending = 0; m_in_frame = 0; m_t = 0;
      m_raw = 16'h0000; m_alarm = 1'b0; m_dv = 1'b0;
    end else begin
      req = start;
      if (enable) begin
        if (m_cnt == P - 1) begin
          m_cnt = 0;
          req = 1;
        end else begin
          m_cnt++;
        end
      end else begin
        m_cnt = 0;
      end
      m_dv = 1'b0;
      consume = !m_in_frame && m_pending;
      if (m_in_frame) begin
        m_t++;
        if (m_t == L) begin
          m_raw = m_word;
          m_alarm = (m_word[15:8] >= thresh);
          m_dv = 1'b1;
        end
        if (m_t == L + CSS) m_in_frame = 0;
      end else if (consume) begin
        m_in_frame = 1;
        m_t = 0;
        m_word = sensor_word;
      end
      m_pending = (m_pending && !consume) || req;
    end
  end

  function automatic logic exp_cs();
    return !(m_in_frame && m_t < L);
  endfunction

  function automatic logic exp_sck();
    int u;
    u = m_t - CSS;
    return m_in_frame && u >= 0 && u < 32 * SD && (u % (2 * SD)) >= SD;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every cycle, DUT outputs against the model.
  always @(posedge clk) begin
    #1;
    chk("cs", 32'(cs), 32'(exp_cs()));
    chk("sck", 32'(sck), 32'(exp_sck()));
    chk("busy", 32'(busy), 32'(m_in_frame));
    chk("temp_raw", 32'(temp_raw), 32'(m_raw));
    chk("temp_data", 32'(temp_data), 32'(m_raw[15:8]));
    chk("data_valid", 32'(data_valid), 32'(m_dv));
    chk("alarm", 32'(alarm), 32'(m_alarm));
  end

  // Waveform-shape monitor used by the literal checks.
  int   cyc = 0, fall_cyc = 0, rise_cyc = 0, last_low_len = 0, last_gap = 0;
  int   sck_rises = 0, frame_sck = 0, dv_count = 0, cs_falls = 0;
  logic cs_q = 1'b1, sck_q = 1'b0;
  always @(posedge clk) begin
    #1;
    cyc++;
    if (cs_q === 1'b1 && cs === 1'b0) begin
      fall_cyc = cyc; last_gap = cyc - rise_cyc; sck_rises = 0; cs_falls++;
    end
    if (cs_q === 1'b0 && cs === 1'b1) begin
      rise_cyc = cyc; last_low_len = cyc - fall_cyc; frame_sck = sck_rises;
    end
    if (sck_q === 1'b0 && sck === 1'b1) sck_rises++;
    if (data_valid === 1'b1) dv_count++;
    cs_q = cs;
    sck_q = sck;
  end

  // Driver tasks (inputs change on the falling edge)
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic wait_dv(input int limit, input string name);
    bit seen = 0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (data_valid === 1'b1) seen = 1;
    end
    chk(name, 32'(seen), 32'd1);
  endtask

  task automatic wait_cs_low(input int limit, input string name);
    bit seen = 0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (cs === 1'b0) seen = 1;
    end
    chk(name, 32'(seen), 32'd1);
  endtask

  task automatic read_word(input logic [15:0] w, input logic [7:0] th);
    sensor_word = w;
    thresh = th;
    pulse_start();
    wait_dv(200, "read_dv_timeout");
    cycles(5);
  endtask

  int dv0;
  int falls0;
  bit hit;

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_cs", 32'(cs), 32'd1);
    chk("rst_sck", 32'(sck), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_raw", 32'(temp_raw), 32'd0);
    chk("rst_dv", 32'(data_valid), 32'd0);
    rst = 1'b0;

    // Single read of 0x0033
    dv0 = dv_count;
    read_word(16'h0033, 8'h01);
    chk("t1_raw", 32'(temp_raw), 32'h0033);
    chk("t1_data", 32'(temp_data), 32'h00);
    chk("t1_alarm", 32'(alarm), 32'd0);
    chk("t1_cs_low_len", 32'(last_low_len), 32'd68);
    chk("t1_sck_pulses", 32'(frame_sck), 32'd16);
    chk("t1_dv_count", 32'(dv_count - dv0), 32'd1);

    // Threshold boundary
    read_word(16'h1980, 8'h19);
    chk("t2_data", 32'(temp_data), 32'h19);
    chk("t2_alarm_eq", 32'(alarm), 32'd1);
    read_word(16'h1980, 8'h1A);
    chk("t2_alarm_below", 32'(alarm), 32'd0);
    thresh = 8'h00;
    chk("t2_thresh_held", 32'(alarm), 32'd0);

    // Periodic reads only
    @(negedge clk) begin rst = 1'b1; enable = 1'b1; end
    @(negedge clk) rst = 1'b0;
    dv0 = dv_count;
    cycles(380);
    chk("t3_periodic_dv", 32'(dv_count - dv0), 32'd3);

    // start coinciding with a timer wrap, then another start mid-frame
    hit = 0;
    for (int i = 0; i < 2 * P && !hit; i++) begin
      @(negedge clk);
      if (m_cnt == P - 1) hit = 1;
    end
    chk("t4_find_wrap", 32'(hit), 32'd1);
    falls0 = cs_falls;
    dv0 = dv_count;
    start = 1'b1;
    @(negedge clk) begin start = 1'b0; enable = 1'b0; end
    wait_cs_low(20, "t4_first_frame");
    cycles(20);
    pulse_start();
    cycles(250);
    chk("t4_frames", 32'(cs_falls - falls0), 32'd2);
    chk("t4_dv", 32'(dv_count - dv0), 32'd2);
    chk("t4_gap", 32'(last_gap), 32'(CSS + 1));

    // Reset during bit 7 of SHIFT
    sensor_word = 16'h5AC3;
    dv0 = dv_count;
    pulse_start();
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      if (sck_rises == 8 && cs === 1'b0) hit = 1;
    end
    chk("t5_reach_bit7", 32'(hit), 32'd1);
    pulse_reset();
    chk("t5_cs", 32'(cs), 32'd1);
    chk("t5_sck", 32'(sck), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_raw", 32'(temp_raw), 32'd0);
    cycles(100);
    chk("t5_no_dv", 32'(dv_count - dv0), 32'd0);
    read_word(16'hA5C3, 8'hA5);
    chk("t5_raw_after", 32'(temp_raw), 32'hA5C3);
    chk("t5_alarm_after", 32'(alarm), 32'd1);

    // Disable the timer mid-frame
    @(negedge clk) enable = 1'b1;
    wait_cs_low(2 * P, "t6_frame_begin");
    cycles(10);
    enable = 1'b0;
    wait_dv(200, "t6_dv");
    dv0 = dv_count;
    cycles(300);
    chk("t6_no_periodic", 32'(dv_count - dv0), 32'd0);
    read_word(16'h7F00, 8'h80);
    chk("t6_start_raw", 32'(temp_raw), 32'h7F00);

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 199) == 0) enable = ~enable;
      if ($urandom_range(0, 49) == 0) thresh = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 9) == 0) sensor_word = 16'($urandom_range(0, 65535));
      rst = ($urandom_range(0, 799) == 0);
    end
    @(negedge clk) begin start = 1'b0; rst = 1'b0; enable = 1'b0; end
    cycles(200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
